// File: rtl/l2_tlb_pkg.sv
// Shared types and constants for the L2 TLB request/response block and its
// permission checker.
package l2_tlb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOOKUP   = 3'd1,
    ST_PTW_REQ  = 3'd2,
    ST_PTW_WAIT = 3'd3,
    ST_RESP     = 3'd4
  } state_e;

  localparam int unsigned PTE_BITS = 5;

  // Flag positions inside the {u,x,w,r,v} PTE field
  localparam int unsigned PTE_V = 0;
  localparam int unsigned PTE_R = 1;
  localparam int unsigned PTE_W = 2;
  localparam int unsigned PTE_X = 3;
  localparam int unsigned PTE_U = 4;

  localparam logic [1:0] PRV_U = 2'd0;
  localparam logic [1:0] PRV_S = 2'd1;
  localparam logic [1:0] PRV_M = 2'd3;

  // Access attributes travelling with a refill request
  typedef struct packed {
    logic       fetch;
    logic       store;
    logic       pum;
    logic       mxr;
    logic [1:0] prv;
  } req_attr_t;

endpackage

// File: rtl/l2_tlb_req_resp_if.sv
// L1-refill and PTW handshake bundle; slave is the L2 TLB, master is the
// L1/PTW environment around it.
interface l2_tlb_req_resp_if
  import l2_tlb_pkg::*;
#(
  parameter int unsigned VPN_BITS = 27,
  parameter int unsigned PPN_BITS = 20
) ();

  logic                io_req_valid;
  logic                io_req_ready;
  logic [VPN_BITS-1:0] io_req_bits_addr;
  logic                io_req_bits_fetch;
  logic                io_req_bits_store;
  logic                io_req_bits_pum;
  logic                io_req_bits_mxr;
  logic [1:0]          io_req_bits_prv;

  logic                io_resp_valid;
  logic [PPN_BITS-1:0] io_resp_bits_ppn;
  logic [PTE_BITS-1:0] io_resp_bits_pte;
  logic                io_resp_bits_xcpt;
  logic                io_resp_bits_hit;

  logic                io_ptw_req_valid;
  logic                io_ptw_req_ready;
  logic [VPN_BITS-1:0] io_ptw_req_bits_addr;
  logic                io_ptw_resp_valid;
  logic [PPN_BITS-1:0] io_ptw_resp_bits_ppn;
  logic [PTE_BITS-1:0] io_ptw_resp_bits_pte;

  logic                io_invalidate;

  modport slave (
    input  io_req_valid, io_req_bits_addr, io_req_bits_fetch, io_req_bits_store,
           io_req_bits_pum, io_req_bits_mxr, io_req_bits_prv,
           io_ptw_req_ready, io_ptw_resp_valid, io_ptw_resp_bits_ppn,
           io_ptw_resp_bits_pte, io_invalidate,
    output io_req_ready, io_resp_valid, io_resp_bits_ppn, io_resp_bits_pte,
           io_resp_bits_xcpt, io_resp_bits_hit,
           io_ptw_req_valid, io_ptw_req_bits_addr
  );

  modport master (
    output io_req_valid, io_req_bits_addr, io_req_bits_fetch, io_req_bits_store,
           io_req_bits_pum, io_req_bits_mxr, io_req_bits_prv,
           io_ptw_req_ready, io_ptw_resp_valid, io_ptw_resp_bits_ppn,
           io_ptw_resp_bits_pte, io_invalidate,
    input  io_req_ready, io_resp_valid, io_resp_bits_ppn, io_resp_bits_pte,
           io_resp_bits_xcpt, io_resp_bits_hit,
           io_ptw_req_valid, io_ptw_req_bits_addr
  );

endinterface

// File: rtl/l2_tlb_perm_check.sv
// Combinational page/permission fault check for one access against a leaf PTE.
// Shared with the L1 TLB so both levels fault identically.
module l2_tlb_perm_check
  import l2_tlb_pkg::*;
(
  input  logic [PTE_BITS-1:0] pte_i,
  input  req_attr_t           attr_i,
  output logic                xcpt_c_o
);

  logic load_c;
  logic exec_fault_c;
  logic store_fault_c;
  logic load_fault_c;
  logic priv_fault_c;

  assign load_c        = !attr_i.fetch && !attr_i.store;
  assign exec_fault_c  = attr_i.fetch && !pte_i[PTE_X];
  assign store_fault_c = attr_i.store && !pte_i[PTE_W];
  // MXR lets loads read execute-only pages
  assign load_fault_c  = load_c && !pte_i[PTE_R] && !(attr_i.mxr && pte_i[PTE_X]);
  // Machine mode bypasses the user/PUM checks entirely
  assign priv_fault_c  = ((attr_i.prv == PRV_U) && !pte_i[PTE_U]) ||
                         ((attr_i.prv == PRV_S) && pte_i[PTE_U] && attr_i.pum);

  assign xcpt_c_o = !pte_i[PTE_V] || exec_fault_c || store_fault_c ||
                    load_fault_c || priv_fault_c;

endmodule

// File: rtl/l2_tlb_req_resp.sv
// Direct-mapped second-level TLB answering L1 refill requests, walking the PTW
// on a miss and filling the entry from the walk result.
module l2_tlb_req_resp
  import l2_tlb_pkg::*;
#(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned VPN_BITS = 27,
  parameter int unsigned PPN_BITS = 20
) (
  input  logic             clock,
  input  logic             reset,
  l2_tlb_req_resp_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = VPN_BITS - IDX_W;

  state_e              state_q;
  logic [VPN_BITS-1:0] addr_q;
  req_attr_t           attr_q;
  logic                inval_seen_q;
  logic                req_ready_q;
  logic                resp_valid_q;
  logic                ptw_req_valid_q;
  logic [PPN_BITS-1:0] resp_ppn_q;
  logic [PTE_BITS-1:0] resp_pte_q;
  logic                resp_xcpt_q;
  logic                resp_hit_q;

  logic [ENTRIES-1:0]  valid_q;
  logic [ENTRIES-1:0]  valid_d;
  logic [TAG_W-1:0]    tag_q [ENTRIES];
  logic [PPN_BITS-1:0] ppn_q [ENTRIES];
  logic [PTE_BITS-1:0] pte_q [ENTRIES];

  logic [IDX_W-1:0]    idx_c;
  logic [TAG_W-1:0]    tag_c;
  logic                hit_c;
  logic                fill_c;
  logic [PTE_BITS-1:0] chk_pte_c;
  logic                xcpt_c;
  req_attr_t           req_attr_c;

  assign idx_c = addr_q[IDX_W-1:0];
  assign tag_c = addr_q[VPN_BITS-1:IDX_W];
  assign hit_c = valid_q[idx_c] && (tag_q[idx_c] == tag_c);

  assign req_attr_c = '{fetch: bus.io_req_bits_fetch, store: bus.io_req_bits_store,
                        pum:   bus.io_req_bits_pum,   mxr:   bus.io_req_bits_mxr,
                        prv:   bus.io_req_bits_prv};

  // Permission check sees the stored PTE during lookup, the walk result otherwise
  assign chk_pte_c = (state_q == ST_LOOKUP) ? pte_q[idx_c] : bus.io_ptw_resp_bits_pte;

  l2_tlb_perm_check u_perm_check (
    .pte_i    (chk_pte_c),
    .attr_i   (attr_q),
    .xcpt_c_o (xcpt_c)
  );

  // A flush anywhere between acceptance and the reply suppresses the fill
  assign fill_c = !reset && (state_q == ST_PTW_WAIT) && bus.io_ptw_resp_valid &&
                  bus.io_ptw_resp_bits_pte[PTE_V] && !inval_seen_q && !bus.io_invalidate;

  always_comb begin
    valid_d = valid_q;
    if (fill_c) valid_d[idx_c] = 1'b1;
    if (bus.io_invalidate) valid_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // Entry payload is qualified by valid_q and therefore needs no reset
  always_ff @(posedge clock) begin
    if (fill_c) begin
      tag_q[idx_c] <= tag_c;
      ppn_q[idx_c] <= bus.io_ptw_resp_bits_ppn;
      pte_q[idx_c] <= bus.io_ptw_resp_bits_pte;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      attr_q          <= '0;
      inval_seen_q    <= 1'b0;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      ptw_req_valid_q <= 1'b0;
      resp_ppn_q      <= '0;
      resp_pte_q      <= '0;
      resp_xcpt_q     <= 1'b0;
      resp_hit_q      <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      if (bus.io_invalidate) inval_seen_q <= 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (req_ready_q && bus.io_req_valid) begin
            addr_q       <= bus.io_req_bits_addr;
            attr_q       <= req_attr_c;
            inval_seen_q <= bus.io_invalidate;
            req_ready_q  <= 1'b0;
            state_q      <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (hit_c) begin
            resp_ppn_q   <= ppn_q[idx_c];
            resp_pte_q   <= pte_q[idx_c];
            resp_xcpt_q  <= xcpt_c;
            resp_hit_q   <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else begin
            ptw_req_valid_q <= 1'b1;
            state_q         <= ST_PTW_REQ;
          end
        end
        ST_PTW_REQ: begin
          if (bus.io_ptw_req_ready) begin
            ptw_req_valid_q <= 1'b0;
            state_q         <= ST_PTW_WAIT;
          end
        end
        ST_PTW_WAIT: begin
          if (bus.io_ptw_resp_valid) begin
            resp_ppn_q   <= bus.io_ptw_resp_bits_ppn;
            resp_pte_q   <= bus.io_ptw_resp_bits_pte;
            resp_xcpt_q  <= xcpt_c;
            resp_hit_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end
        end
        ST_RESP: begin
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          req_ready_q     <= 1'b1;
          ptw_req_valid_q <= 1'b0;
          state_q         <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.io_req_ready         = req_ready_q;
  assign bus.io_resp_valid        = resp_valid_q;
  assign bus.io_resp_bits_ppn     = resp_ppn_q;
  assign bus.io_resp_bits_pte     = resp_pte_q;
  assign bus.io_resp_bits_xcpt    = resp_xcpt_q;
  assign bus.io_resp_bits_hit     = resp_hit_q;
  assign bus.io_ptw_req_valid     = ptw_req_valid_q;
  assign bus.io_ptw_req_bits_addr = addr_q;

endmodule
